button_step_conditioner: RTL and testbench
==========================================

Name: button_step_conditioner

Overview:
Upstream stage for the 7-segment letter sequencer. It turns a raw, bouncing push-button on a dedicated input pin into a clean one-clock step strobe in the system clock domain. The sequencer advances on that strobe instead of clocking directly off the pad. It also outputs a debounced level and a wrap-around step counter for observability.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive stable clock cycles needed to accept a press or a release; legal range 2..65535.
REPEAT_DELAY, 5000000, cycles the button must be held before the first auto-repeat strobe (used only with AUTO_REPEAT_EN).
REPEAT_PERIOD, 2000000, cycles between later auto-repeat strobes (used only with AUTO_REPEAT_EN).

Ports:
clk  input  1  system clock; the only clock in the block
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
ena  input  1  block enable; 0 forces IDLE and suppresses strobes
btn_in  input  1  raw asynchronous button level, active high
step_pulse  output  1  one-cycle strobe, high for exactly one clk cycle per accepted step
btn_level  output  1  debounced button level
step_count  output  8  count of step_pulse strobes, wraps 255 to 0

Behaviour:
- Reset: rst_n=0 at a clk edge sets step_pulse=0, btn_level=0, step_count=0, both synchronizer flops=0, debounce counter=0, repeat counter=0, and the state machine to IDLE. Asserting reset in the middle of an operation aborts it and emits no strobe.
- Synchronizer: btn_in passes through two flops to give btn_sync. No other logic reads btn_in.
- Debounce counter: width is clog2(DEBOUNCE_CYCLES). It clears on every state entry.
- IDLE (btn_level=0): if btn_sync=1, go to PRESS_WAIT.
- PRESS_WAIT: if btn_sync=0, return to IDLE (glitch rejected, no strobe). Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1 and btn_sync=1, go to PRESSED, set btn_level=1 and register step_pulse=1 for the next cycle only.
- PRESSED (btn_level=1): if btn_sync=0, go to RELEASE_WAIT.
- RELEASE_WAIT: if btn_sync=1, return to PRESSED (no strobe, btn_level stays 1). When the counter equals DEBOUNCE_CYCLES-1 and btn_sync=0, go to IDLE with btn_level=0.
- Latency: suppose btn_in is stable high before clk edge k. Then PRESS_WAIT is entered at edge k+2, and step_pulse is high in the cycle after edge k+2+DEBOUNCE_CYCLES. The release path has the same latency for btn_level falling.
- Strobe limit: at most one strobe per debounced press, unless auto-repeat is enabled. step_pulse is never high on two consecutive cycles.
- step_count increments by 1 modulo 256 in the same cycle step_pulse is high.
- ena=0: state goes to IDLE, the counter clears, step_pulse=0 and btn_level=0. step_count holds its value. The synchronizer keeps running.
- Simultaneous events: if rst_n=0 and ena=0 together, reset wins. If btn_sync drops on the same edge the counter reaches DEBOUNCE_CYCLES-1 in PRESS_WAIT, the state goes to IDLE with no strobe.

Optional Feature:
Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: in PRESSED a repeat counter runs from state entry.
  - After REPEAT_DELAY cycles in PRESSED, emit one extra step_pulse.
  - After that, emit one every REPEAT_PERIOD cycles while the state stays PRESSED.
  - Each repeat strobe increments step_count.
  - Leaving PRESSED (including a bounce into RELEASE_WAIT) clears the repeat counter and restarts the full REPEAT_DELAY.
- Undefined: the repeat logic is absent. PRESSED emits no strobes. REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
1. Reset: hold rst_n=0 for 3 cycles with btn_in=1, then release -> step_pulse=0, btn_level=0, step_count=0 during reset; first strobe 6 cycles after rst_n rises (with btn_in held high).
2. Clean press: btn_in rises before edge 10 and is held -> step_pulse high only in the cycle after edge 16; step_count=1; btn_level=1 from the same cycle.
3. Bounce: btn_in pulses high for 3 cycles, low for 1, then high steadily -> no strobe from the short pulse; exactly one strobe 6 cycles after the final rise; step_count=1.
4. Release bounce: while PRESSED, drop btn_in for 2 cycles then raise it -> btn_level stays 1 and no new strobe; a later clean release drops btn_level 6 cycles after the fall.
5. Counter wrap: drive 256 clean press/release pairs -> step_count returns to 0 and sees exactly 256 single-cycle strobes; ena=0 mid-press -> btn_level=0, no strobe, step_count unchanged.
6. With BUTTON_AUTO_REPEAT_EN, hold 30 cycles after acceptance -> strobes at PRESSED-entry+0, +8, +11, +14, ...; without the macro, the same stimulus gives exactly one strobe.

Source files
------------

// File: rtl/button_step_conditioner.sv
// Turns a raw bouncing push-button into a debounced level and a one-clock step strobe.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat strobes while the button stays pressed.
module button_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_in,
    output logic       step_pulse,
    output logic       btn_level,
    output logic [7:0] step_count
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_pulse_q, step_pulse_d;
    logic [7:0]    step_count_q, step_count_d;
    logic          btn_sync;
    logic          accept;
    logic          rpt_fire;

    assign btn_sync = sync_q[1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_d;
        end
    end

    // Next-state logic; the debounce counter restarts from zero on every state change
    always_comb begin
        sync_d  = {sync_q[0], btn_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_sync) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    // Repeat counter restarts on every entry into PRESSED; the first interval is REPEAT_DELAY,
    // later ones REPEAT_PERIOD. Both are expected to be at least 2.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_armed_q, rpt_armed_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    always_comb begin
        rpt_d       = '0;
        rpt_armed_d = 1'b0;
        rpt_fire    = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rpt_q == (rpt_armed_q ? RPT_NEXT : RPT_FIRST)) begin
                rpt_fire    = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_d       = rpt_q + 1'b1;
                rpt_armed_d = rpt_armed_q;
            end
        end
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire       = 1'b0;
`endif

    // Output logic
    always_comb begin
        step_pulse_d = ena & (accept | rpt_fire);
        step_count_d = step_count_q + {7'd0, step_pulse_d};
        step_pulse   = step_pulse_q;
        step_count   = step_count_q;
        btn_level    = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_button_step_conditioner.sv
// Randomized self-checking bench for button_step_conditioner against a run-length reference model.
module tb_button_step_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       btn_in = 1'b0;
    logic       step_pulse;
    logic       btn_level;
    logic [7:0] step_count;

    int n_checks = 0;
    int n_fail   = 0;
    int seen_strobes = 0;
    string phase = "init";

    int exp_level = 0;
    int exp_pulse = 0;
    int exp_count = 0;
    int run   = 0;
    int since = 0;
    int hist[$];

    button_step_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_in    (btn_in),
        .step_pulse(step_pulse),
        .btn_level (btn_level),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d at %0t", phase, tag, actual, expected, $time);
        end
    endtask

    // The debouncer accepts a change once the synchronized input has differed from the
    // accepted level for D+1 consecutive clock edges; the synchronizer is a 2-edge delay.
    task automatic model_step();
        int s;
        if (!rst_n) begin
            hist = {};
            hist.push_back(0);
            hist.push_back(0);
            exp_level = 0;
            exp_pulse = 0;
            exp_count = 0;
            run   = 0;
            since = 0;
        end else begin
            hist.push_back(int'(btn_in));
            s = hist.pop_front();
            exp_pulse = 0;
            if (!ena) begin
                exp_level = 0;
                run   = 0;
                since = 0;
            end else if (s != exp_level) begin
                run++;
                if (run == D + 1) begin
                    exp_level = 1 - exp_level;
                    run   = 0;
                    since = 0;
                    exp_pulse = exp_level;
                end
            end else begin
                if (run != 0) begin
                    since = 0;
                end else if (exp_level == 1) begin
                    since++;
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (since == RD || (since > RD && (since - RD) % RP == 0))
                        exp_pulse = 1;
`endif
                end
                run = 0;
            end
            exp_count = (exp_count + exp_pulse) % 256;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (step_pulse === 1'b1)
            seen_strobes++;
        check_value("step_pulse", 32'(step_pulse), exp_pulse);
        check_value("btn_level", 32'(btn_level), exp_level);
        check_value("step_count", 32'(step_count), exp_count);
    endtask

    task automatic hold(input logic val, input int n);
        btn_in = val;
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        int count_start;
        int strobes_start;
        int len;

        hist.push_back(0);
        hist.push_back(0);

        phase = "reset";
        rst_n = 1'b0;
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 12);
        $display("[%s] step_count=%0d level=%0d", phase, step_count, btn_level);

        phase = "release";
        hold(1'b0, 10);
        $display("[%s] step_count=%0d level=%0d", phase, step_count, btn_level);

        phase = "bounce";
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 12);
        $display("[%s] step_count=%0d level=%0d", phase, step_count, btn_level);

        phase = "release_bounce";
        hold(1'b0, 2);
        hold(1'b1, 6);
        hold(1'b0, 10);
        $display("[%s] step_count=%0d level=%0d", phase, step_count, btn_level);

        phase = "wrap";
        count_start   = exp_count;
        strobes_start = seen_strobes;
        for (int p = 0; p < 256; p++) begin
            hold(1'b1, D + 4);
            hold(1'b0, D + 4);
        end
        check_value("wrap_count", 32'(step_count), count_start);
        check_value("wrap_strobes", seen_strobes - strobes_start, 256);
        $display("[%s] step_count=%0d strobes=%0d", phase, step_count, seen_strobes - strobes_start);

        phase = "ena_off";
        count_start = exp_count;
        hold(1'b1, D + 1);
        ena = 1'b0;
        hold(1'b1, 4);
        check_value("ena_count_hold", 32'(step_count), count_start);
        ena = 1'b1;
        hold(1'b1, 12);
        ena = 1'b0;
        hold(1'b1, 2);
        ena = 1'b1;
        hold(1'b0, 10);
        $display("[%s] step_count=%0d level=%0d", phase, step_count, btn_level);

        phase = "hold_repeat";
        hold(1'b1, D + 2 + 30);
        hold(1'b0, 10);
        $display("[%s] step_count=%0d level=%0d", phase, step_count, btn_level);

        phase = "random";
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(63) == 0) begin
                rst_n = 1'b0;
                hold(btn_in, 1 + $urandom_range(1));
                rst_n = 1'b1;
            end
            ena = ($urandom_range(31) != 0);
            len = ($urandom_range(7) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 3 * D);
            hold(1'($urandom_range(1)), len);
        end
        ena = 1'b1;
        $display("[%s] step_count=%0d strobes=%0d", phase, step_count, seen_strobes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
